xor_burst_acc: RTL and testbench
================================

XOR_BURST_ACC -- requirements
Module: xor_burst_acc

Interface
REQ-001 Parameter NBITS, default 8: width of data byte lane and of both result words.
REQ-002 Parameter LBITS, default 8: width of burst-length input and internal counter.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 START  in  1  begin burst; sampled only in IDLE.
REQ-006 LEN  in  LBITS  burst length in words, sampled with START.
REQ-007 XIN  in  NBITS  data word from upstream bitwise-XOR stage (its XOUT).
REQ-008 XIN_VALID  in  1  XIN holds a valid word.
REQ-009 XIN_READY  out  1  block accepts XIN this cycle.
REQ-010 XACC  out  NBITS  XOR-fold of all accepted words of the burst.
REQ-011 SACC  out  NBITS  sum modulo 2**NBITS of all accepted words of the burst.
REQ-012 RES_VALID  out  1  XACC/SACC final and stable.
REQ-013 RES_READY  in  1  consumer takes result.
REQ-014 BUSY  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be exactly IDLE, ACC, DONE, encoded as a 2-bit enum.
REQ-016 IDLE: XIN_READY=0, RES_VALID=0; START=1 and LEN!=0 -> ACC, counter:=LEN, XACC:=0, SACC:=0.
REQ-017 IDLE: START=1 and LEN=0 -> DONE directly with XACC=0, SACC=0.
REQ-018 ACC: XIN_READY=1 combinationally from state only; never dependent on XIN_VALID.
REQ-019 Word accepted iff XIN_VALID and XIN_READY high at the rising edge; XACC:=XACC^XIN, SACC:=SACC+XIN (carry discarded), counter:=counter-1.
REQ-020 XIN_VALID low in ACC: no state, counter or accumulator change; stalls of any length allowed.
REQ-021 Accept with counter=1 -> DONE next edge; RES_VALID high first cycle after last accept (latency 1).
REQ-022 DONE: XIN_READY=0; RES_VALID=1; XACC/SACC held constant until handshake.
REQ-023 DONE with RES_READY=1 -> IDLE next edge; XACC/SACC keep last values in IDLE.
REQ-024 START outside IDLE SHALL be ignored; LEN outside IDLE SHALL be ignored.
REQ-025 LEN=2**LBITS-1 SHALL run the full count without counter wrap.
REQ-026 Outputs SHALL be registered or decoded from state only; no combinational path XIN->XACC/SACC.

Reset
REQ-027 RST_N low SHALL immediately force IDLE, counter=0, XACC=0, SACC=0, RES_VALID=0, XIN_READY=0, BUSY=0.
REQ-028 Reset mid-burst SHALL discard partial accumulation; first edge after release is in IDLE.

Structure
REQ-029 State enum and its encoding SHALL live in the shared package alongside the existing support functions.
REQ-030 No sub-module; the upstream bitwise-XOR stage is instantiated by the bench, not inside this block.

Verification
REQ-031 LEN=3, words 0x0F,0xF0,0x55 with no stalls -> RES_VALID 1 cycle after 3rd accept, XACC=0xAA, SACC=0x54.
REQ-032 LEN=2, words 0xFF,0x02 with 4 idle cycles of XIN_VALID=0 between -> XACC=0xFD, SACC=0x01, no extra accept.
REQ-033 START with LEN=0 -> DONE next edge, XACC=0, SACC=0; RES_READY held low 5 cycles -> RES_VALID stays 1, values stable.
REQ-034 START pulsed in ACC and DONE with LEN=7 -> ignored; burst completes with original count.
REQ-035 RST_N low after 2 of 4 words -> outputs zero same cycle; new burst LEN=1 word 0x3C -> XACC=0x3C, SACC=0x3C.
REQ-036 Upstream A=0xA5, B=0x5A driven through XOR stage, LEN=1 -> XACC=0xFF, SACC=0xFF.

Source files
------------

// File: rtl/xor_burst_acc_pkg.sv
// Shared definitions for the XOR/sum burst accumulator: FSM state type,
// default widths and small state-decode helpers.
package xor_burst_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_NBITS = 8;
   localparam int DEFAULT_LBITS = 8;

   function automatic logic isBusy(input state_t s);
      return s != IDLE;
   endfunction

   function automatic logic takesWords(input state_t s);
      return s == ACC;
   endfunction

   function automatic logic hasResult(input state_t s);
      return s == DONE;
   endfunction

endpackage

// File: rtl/xor_burst_acc_if.sv
// Burst control, data-in and result handshake bundle for xor_burst_acc.
// The master side issues bursts and words; the slave side is the accumulator.
interface xor_burst_acc_if #(
   parameter int NBITS = 8,
   parameter int LBITS = 8
);
   logic             start;
   logic [LBITS-1:0] len;
   logic [NBITS-1:0] xin;
   logic             xin_valid;
   logic             xin_ready;
   logic [NBITS-1:0] xacc;
   logic [NBITS-1:0] sacc;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   modport master (
      output start, len, xin, xin_valid, res_ready,
      input  xin_ready, xacc, sacc, res_valid, busy
   );

   modport slave (
      input  start, len, xin, xin_valid, res_ready,
      output xin_ready, xacc, sacc, res_valid, busy
   );
endinterface

// File: rtl/xor_burst_acc.sv
// Accumulates a burst of LEN words into an XOR-fold and a modular sum,
// then holds both until the consumer takes the result.
module xor_burst_acc
   import xor_burst_acc_pkg::*;
#(
   parameter int NBITS = DEFAULT_NBITS,
   parameter int LBITS = DEFAULT_LBITS
) (
   input  logic           clk,
   input  logic           rst_n,
   xor_burst_acc_if.slave bus
);

   state_t           r_state;
   state_t           w_nextState;
   logic [LBITS-1:0] r_count;
   logic [NBITS-1:0] r_xacc;
   logic [NBITS-1:0] r_sacc;
   logic             w_accept;
   logic             w_lastWord;

   assign w_accept   = takesWords(r_state) && bus.xin_valid;
   assign w_lastWord = (r_count == LBITS'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A zero-length burst skips ACC and presents the cleared result at once.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_nextState = (bus.len == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            if (w_accept && w_lastWord) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Accumulators are only cleared by a new START, so the last result
   // remains visible after the handshake returns the block to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_xacc  <= '0;
         r_sacc  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_count <= bus.len;
                  r_xacc  <= '0;
                  r_sacc  <= '0;
               end
            end
            ACC: begin
               if (w_accept) begin
                  r_count <= r_count - LBITS'(1);
                  r_xacc  <= r_xacc ^ bus.xin;
                  r_sacc  <= r_sacc + bus.xin;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.xin_ready = takesWords(r_state);
   assign bus.res_valid = hasResult(r_state);
   assign bus.busy      = isBusy(r_state);
   assign bus.xacc      = r_xacc;
   assign bus.sacc      = r_sacc;

endmodule

// File: tb/tb_xor_burst_acc.sv
// Self-checking bench for xor_burst_acc: directed vector table, multi-cycle
// corner sequences and randomized bursts against a fold-based reference.
module tb_xor_burst_acc;

   localparam int NBITS = 8;
   localparam int LBITS = 8;

   typedef struct packed {
      logic [7:0]      len;
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      logic [7:0]      stall;
      logic [7:0]      expX;
      logic [7:0]      expS;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   totalCount = 0;
   int   badCount   = 0;

   logic [7:0] wordQ[$];
   vec_t       vecs[5];

   xor_burst_acc_if #(.NBITS(NBITS), .LBITS(LBITS)) bus();

   xor_burst_acc #(.NBITS(NBITS), .LBITS(LBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      totalCount++;
      if (got !== exp) begin
         badCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] refXor();
      logic [7:0] r = 8'h00;
      foreach (wordQ[i]) r = r ^ wordQ[i];
      return r;
   endfunction

   function automatic logic [7:0] refSum();
      int s = 0;
      foreach (wordQ[i]) s = s + int'(wordQ[i]);
      return 8'(s % 256);
   endfunction

   // Runs one burst of wordQ, optionally stalling between words and pulsing START mid-burst.
   task automatic applyStimulus(input int len, input int stall, input int startPulseAt);
      bus.start = 1'b1;
      bus.len   = 8'(len);
      step();
      bus.start = 1'b0;
      for (int i = 0; i < len; i++) begin
         bus.xin       = wordQ[i];
         bus.xin_valid = 1'b1;
         if (i == startPulseAt) begin
            bus.start = 1'b1;
            bus.len   = 8'd2;
         end
         checkOutput("xin_ready in burst", 32'(bus.xin_ready), 32'd1);
         checkOutput("no early result", 32'(bus.res_valid), 32'd0);
         step();
         bus.start     = 1'b0;
         bus.xin_valid = 1'b0;
         if (i != len - 1) begin
            for (int s = 0; s < stall; s++) begin
               bus.xin = 8'($urandom);
               step();
            end
         end
      end
      checkOutput("res_valid latency", 32'(bus.res_valid), 32'd1);
      checkOutput("xin_ready low in done", 32'(bus.xin_ready), 32'd0);
   endtask

   task automatic takeResult();
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      checkOutput("res_valid after take", 32'(bus.res_valid), 32'd0);
      checkOutput("busy after take", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] heldX;
      logic [7:0] heldS;
      int         taken;
      int         len;
      int         cycles;

      bus.start     = 1'b0;
      bus.len       = '0;
      bus.xin       = '0;
      bus.xin_valid = 1'b0;
      bus.res_ready = 1'b0;

      vecs[0] = '{len: 8'd3, a: {8'h00, 8'h55, 8'hF0, 8'h0F}, b: '0, stall: 8'd0, expX: 8'hAA, expS: 8'h54};
      vecs[1] = '{len: 8'd2, a: {8'h00, 8'h00, 8'h02, 8'hFF}, b: '0, stall: 8'd4, expX: 8'hFD, expS: 8'h01};
      vecs[2] = '{len: 8'd1, a: {8'h00, 8'h00, 8'h00, 8'hA5}, b: {8'h00, 8'h00, 8'h00, 8'h5A}, stall: 8'd0, expX: 8'hFF, expS: 8'hFF};
      vecs[3] = '{len: 8'd3, a: {8'h00, 8'h04, 8'h02, 8'h01}, b: '0, stall: 8'd1, expX: 8'h07, expS: 8'h07};
      vecs[4] = '{len: 8'd4, a: {8'h80, 8'h80, 8'h80, 8'h80}, b: '0, stall: 8'd2, expX: 8'h00, expS: 8'h00};

      // Reset state
      step();
      step();
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset xin_ready", 32'(bus.xin_ready), 32'd0);
      checkOutput("reset res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("reset xacc", 32'(bus.xacc), 32'd0);
      checkOutput("reset sacc", 32'(bus.sacc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed table; word i is the upstream XOR stage output a[i]^b[i]
      for (int v = 0; v < 5; v++) begin
         wordQ.delete();
         for (int i = 0; i < int'(vecs[v].len); i++) wordQ.push_back(vecs[v].a[i] ^ vecs[v].b[i]);
         applyStimulus(int'(vecs[v].len), int'(vecs[v].stall), -1);
         checkOutput($sformatf("vec%0d xacc", v), 32'(bus.xacc), 32'(vecs[v].expX));
         checkOutput($sformatf("vec%0d sacc", v), 32'(bus.sacc), 32'(vecs[v].expS));
         takeResult();
         checkOutput($sformatf("vec%0d xacc kept in idle", v), 32'(bus.xacc), 32'(vecs[v].expX));
      end

      // Zero-length burst goes straight to DONE with cleared results, held until taken
      wordQ = '{8'h12, 8'h34};
      applyStimulus(2, 0, -1);
      takeResult();
      bus.start = 1'b1;
      bus.len   = 8'd0;
      step();
      bus.start = 1'b0;
      checkOutput("len0 res_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("len0 busy", 32'(bus.busy), 32'd1);
      for (int c = 0; c < 5; c++) begin
         step();
         checkOutput("len0 res_valid held", 32'(bus.res_valid), 32'd1);
         checkOutput("len0 xacc", 32'(bus.xacc), 32'd0);
         checkOutput("len0 sacc", 32'(bus.sacc), 32'd0);
      end
      takeResult();

      // START in ACC and in DONE is ignored
      wordQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      applyStimulus(7, 1, 2);
      bus.start = 1'b1;
      bus.len   = 8'd3;
      step();
      bus.start = 1'b0;
      checkOutput("start in done ignored", 32'(bus.res_valid), 32'd1);
      checkOutput("len7 xacc", 32'(bus.xacc), 32'h00);
      checkOutput("len7 sacc", 32'(bus.sacc), 32'h1C);
      takeResult();

      // Reset mid-burst takes effect immediately and discards partial results
      wordQ = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.start = 1'b1;
      bus.len   = 8'd4;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.xin       = wordQ[i];
         bus.xin_valid = 1'b1;
         step();
      end
      bus.xin_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset xacc", 32'(bus.xacc), 32'd0);
      checkOutput("async reset sacc", 32'(bus.sacc), 32'd0);
      checkOutput("async reset busy", 32'(bus.busy), 32'd0);
      checkOutput("async reset xin_ready", 32'(bus.xin_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checkOutput("idle after reset release", 32'(bus.busy), 32'd0);
      wordQ = '{8'h3C};
      applyStimulus(1, 0, -1);
      checkOutput("post-reset xacc", 32'(bus.xacc), 32'h3C);
      checkOutput("post-reset sacc", 32'(bus.sacc), 32'h3C);
      takeResult();

      // Maximum length runs its full count
      wordQ.delete();
      for (int i = 0; i < 255; i++) wordQ.push_back(8'h01);
      applyStimulus(255, 0, -1);
      checkOutput("len255 xacc", 32'(bus.xacc), 32'(refXor()));
      checkOutput("len255 sacc", 32'(bus.sacc), 32'(refSum()));
      takeResult();

      // Randomized bursts with random stalls against the fold reference
      for (int b = 0; b < 25; b++) begin
         len = $urandom_range(1, 12);
         wordQ.delete();
         taken = 0;
         cycles = 0;
         bus.start = 1'b1;
         bus.len   = 8'(len);
         step();
         bus.start = 1'b0;
         while (taken < len && cycles < 200) begin
            bus.xin_valid = ($urandom_range(0, 3) != 0);
            bus.xin       = 8'($urandom);
            if (bus.start !== 1'b0) bus.start = 1'b0;
            checkOutput("rand xin_ready", 32'(bus.xin_ready), 32'd1);
            step();
            if (bus.xin_valid) begin
               wordQ.push_back(bus.xin);
               taken++;
            end
            cycles++;
         end
         bus.xin_valid = 1'b0;
         checkOutput("rand burst finished in budget", 32'(taken), 32'(len));
         checkOutput("rand res_valid", 32'(bus.res_valid), 32'd1);
         checkOutput("rand xacc", 32'(bus.xacc), 32'(refXor()));
         checkOutput("rand sacc", 32'(bus.sacc), 32'(refSum()));
         for (int d = 0; d < int'($urandom_range(0, 2)); d++) step();
         takeResult();
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
